// File: rtl/axil_regfile_pkg.sv
// Shared types and helpers for the AXI-Lite register file: response codes,
// write/read channel state encodings and register-index width.
package axil_regfile_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // Width of a register index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI-Lite bus bundle for the register file; master drives requests, slave responds.
interface axil_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_regfile_decode.sv
// Byte address to register index decode with range and read-only classification.
module axil_regfile_decode
  import axil_regfile_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  output logic [idx_width(NUM_REGS)-1:0]   idx,
  output logic                             in_range,
  output logic                             ro
);

  localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = idx_width(NUM_REGS);

  logic [ADDR_WIDTH-1:0] word;

  assign word     = addr >> SHIFT;
  assign idx      = word[IDX_W-1:0];
  // NUM_REGS is a power of two, so any bit above the index means out of range.
  assign in_range = ((word >> IDX_W) == '0);
  assign ro       = in_range && RO_MASK[idx];

endmodule

// File: rtl/axil_regfile.sv
// AXI-Lite slave register file with byte strobes, read-only slots fed from ro_d,
// and a per-register commit strobe. One write and one read may be in flight.
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  axil_regfile_if.slave                    bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   ro_d,
  output logic [NUM_REGS-1:0]              wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = idx_width(NUM_REGS);

  // Keeps readies low until the first clock edge after reset is released.
  logic live_q;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  r_state_e              r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] regs_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d   [NUM_REGS];
  logic [DATA_WIDTH-1:0] ro_words [NUM_REGS];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_in_range, wr_ro, rd_in_range, rd_ro;
  logic             aw_hs, w_hs, ar_hs;

  axil_regfile_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_wr_decode (
    .addr     (aw_addr_q),
    .idx      (wr_idx),
    .in_range (wr_in_range),
    .ro       (wr_ro)
  );

  axil_regfile_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_rd_decode (
    .addr     (bus.araddr),
    .idx      (rd_idx),
    .in_range (rd_in_range),
    .ro       (rd_ro)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    assign ro_words[i]                       = ro_d[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.awready = live_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_W);
  assign bus.wready  = live_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_A);
  assign bus.bvalid  = (w_state_q == W_RESP);
  assign bus.bresp   = bresp_q;
  assign bus.arready = live_q && (r_state_q == R_IDLE);
  assign bus.rvalid  = (r_state_q == R_DATA);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign wr_pulse    = wr_pulse_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;

  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (aw_hs) begin
      aw_addr_d = bus.awaddr;
    end
    if (w_hs) begin
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_COMMIT;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          w_state_d = W_COMMIT;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        w_state_d = W_RESP;
        if (!wr_in_range || wr_ro) begin
          bresp_d = SLVERR;
        end else begin
          bresp_d            = OKAY;
          wr_pulse_d[wr_idx] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) begin
              regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
            end
          end
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          if (!rd_in_range) begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end else begin
            // regs_q is the pre-commit value when a write lands on the same edge.
            rdata_d = rd_ro ? ro_words[rd_idx] : regs_q[rd_idx];
            rresp_d = OKAY;
          end
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q     <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      live_q     <= 1'b1;
      w_state_q  <= w_state_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile: 32-bit data, 16 registers, register 2 read-only.
module tb_axil_regfile;
  import axil_regfile_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] reg_q;
  logic [511:0] ro_d;
  logic [15:0]  wr_pulse;

  int checks = 0;
  int errors = 0;

  axil_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axil_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .NUM_REGS   (16),
    .RO_MASK    (16'h0004)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .reg_q    (reg_q),
    .ro_d     (ro_d),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  // W is presented w_lead cycles before AW (0 = same cycle).
  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           output logic [1:0] resp, output logic [15:0] pulse,
                           output int lat);
    @(negedge clk);
    bus.wvalid = 1'b1;
    bus.wdata  = data;
    bus.wstrb  = strb;
    if (w_lead == 0) begin
      bus.awvalid = 1'b1;
      bus.awaddr  = addr;
    end
    for (int k = 1; k <= w_lead; k++) begin
      @(negedge clk);
      bus.wvalid = 1'b0;
      check("awready_held", bus.awready, 1);
      if (k == w_lead) begin
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
      end
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    lat = 0;
    while (!bus.bvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    resp  = bus.bresp;
    pulse = wr_pulse;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic read_txn(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    @(negedge clk);
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   resp;
    logic [15:0]  pulse;
    logic [31:0]  data;
    logic [511:0] snap;
    int           lat;

    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    ro_d = '0;
    ro_d[2*32 +: 32] = 32'hA5A5_A5A5;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_resp", {bus.bresp, bus.rresp}, 0);
    check("rst_regs_zero", (reg_q == '0), 1);
    check("rst_wr_pulse", wr_pulse, 0);
    reset = 1'b0;
    #1;
    check("rel_awready_early", bus.awready, 0);
    @(negedge clk);
    check("rel_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // AW and W together
    write_txn(8'h04, 32'hDEAD_BEEF, 4'hF, 0, resp, pulse, lat);
    check("wr1_lat", lat, 1);
    check("wr1_resp", resp, OKAY);
    check("wr1_pulse", pulse, 16'h0002);
    check("wr1_reg1", word(1), 32'hDEAD_BEEF);
    check("wr1_pulse_gone", wr_pulse, 0);
    check("wr1_ready_back", {bus.awready, bus.wready}, 2'b11);
    read_txn(8'h04, data, resp, lat);
    check("rd1_lat", lat, 0);
    check("rd1_data", data, 32'hDEAD_BEEF);
    check("rd1_resp", resp, OKAY);

    // W three cycles ahead of AW, partial strobe
    write_txn(8'h04, 32'h1234_5678, 4'h3, 3, resp, pulse, lat);
    check("wr2_resp", resp, OKAY);
    check("wr2_lat", lat, 1);
    check("wr2_reg1", word(1), 32'hDEAD_5678);

    // Zero strobe: no change, still pulses and OKAY
    write_txn(8'h04, 32'hFFFF_FFFF, 4'h0, 0, resp, pulse, lat);
    check("wr0_resp", resp, OKAY);
    check("wr0_pulse", pulse, 16'h0002);
    check("wr0_reg1", word(1), 32'hDEAD_5678);

    // Out of range
    snap = reg_q;
    write_txn(8'h40, 32'h0BAD_0BAD, 4'hF, 0, resp, pulse, lat);
    check("oor_wr_resp", resp, SLVERR);
    check("oor_wr_pulse", pulse, 0);
    check("oor_wr_regs", (reg_q == snap), 1);
    read_txn(8'h40, data, resp, lat);
    check("oor_rd_data", data, 0);
    check("oor_rd_resp", resp, SLVERR);

    // Read-only register 2
    write_txn(8'h08, 32'h1111_1111, 4'hF, 0, resp, pulse, lat);
    check("ro_wr_resp", resp, SLVERR);
    check("ro_wr_pulse", pulse, 0);
    check("ro_wr_reg2", word(2), 0);
    read_txn(8'h08, data, resp, lat);
    check("ro_rd_data", data, 32'hA5A5_A5A5);
    check("ro_rd_resp", resp, OKAY);

    // Last register, top byte lane; byte-offset bits ignored on read
    write_txn(8'h3C, 32'h0F0F_0F0F, 4'h8, 0, resp, pulse, lat);
    check("r15_pulse", pulse, 16'h8000);
    check("r15_reg", word(15), 32'h0F00_0000);
    read_txn(8'h3F, data, resp, lat);
    check("r15_rd_data", data, 32'h0F00_0000);
    check("r15_rd_resp", resp, OKAY);
    read_txn(8'h07, data, resp, lat);
    check("off_rd_data", data, 32'hDEAD_5678);

    // Read on the same edge as a commit to the same register sees the old value
    write_txn(8'h14, 32'h0BAD_F00D, 4'hF, 0, resp, pulse, lat);
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 8'h14;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_BABE; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 8'h14;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("same_edge_rvalid", bus.rvalid, 1);
    check("same_edge_rdata", bus.rdata, 32'h0BAD_F00D);
    check("same_edge_bvalid", bus.bvalid, 1);
    check("same_edge_reg5", word(5), 32'hCAFE_BABE);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("same_edge_done", {bus.bvalid, bus.rvalid}, 2'b00);

    // rready held low
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 8'h04;
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("rstall_rvalid", bus.rvalid, 1);
      check("rstall_rdata", bus.rdata, 32'hDEAD_5678);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rstall_done", bus.rvalid, 0);

    // bready held low
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 8'h0C;
    bus.wvalid = 1'b1; bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bstall_bvalid", bus.bvalid, 1);
      check("bstall_readies", {bus.awready, bus.wready}, 2'b00);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bstall_done", bus.bvalid, 0);
    check("bstall_ready_back", {bus.awready, bus.wready}, 2'b11);
    check("bstall_reg3", word(3), 32'h1122_3344);

    // Reset while holding an address only
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 8'h0C;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("have_a_readies", {bus.awready, bus.wready}, 2'b01);
    reset = 1'b1;
    #1;
    check("midrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_rel_early", bus.awready, 0);
    @(negedge clk);
    check("midrst_rel_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("midrst_no_bvalid", bus.bvalid, 0);
    bus.wvalid = 1'b1; bus.wdata = 32'h55AA_55AA; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.wvalid = 1'b0;
    @(negedge clk);
    check("midrst_w_only_bvalid", bus.bvalid, 0);
    check("midrst_w_only_pulse", wr_pulse, 0);
    check("midrst_reg3", word(3), 0);
    bus.awvalid = 1'b1; bus.awaddr = 8'h10;
    @(negedge clk);
    bus.awvalid = 1'b0;
    @(negedge clk);
    check("midrst_bvalid", bus.bvalid, 1);
    check("midrst_reg4", word(4), 32'h55AA_55AA);
    check("midrst_reg3_after", word(3), 0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
